// File: rtl/fir_axil_ctrl.sv
// rtl/fir_axil_ctrl.sv - AXI-Lite config responder for the FIR engine: ap_ctrl, data_length, tap BRAM window.
// Owns the tap BRAM port when idle and hands it to the stream engine while a run is in flight.
module fir_axil_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start_o,
    input  logic                   eng_done_i,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic [pDATA_WIDTH-1:0] data_length
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32'h20 + 4 * (Tape_Num - 1));

    typedef enum logic {W_IDLE, W_ACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_BRAM, R_DATA} r_state_t;

    w_state_t               w_state;
    r_state_t               r_state;
    logic [pADDR_WIDTH-1:0] w_addr;
    logic [pDATA_WIDTH-1:0] w_data;
    logic [pADDR_WIDTH-1:0] r_addr;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [pDATA_WIDTH-1:0] reg_rdata;
    logic                   bram_fresh;
    logic                   rd_hold;
    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   wr_tap;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
    endfunction

    assign wr_tap = (w_state == W_ACK) && is_tap(w_addr) && ap_idle;

    // BRAM data is only valid in the first R_DATA cycle; it is captured then and held
    assign rdata = bram_fresh ? tap_Do : rdata_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && wvalid) begin
                        w_state <= W_ACK;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_addr  <= awaddr;
                        w_data  <= wdata;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (r_addr == ADDR_CTRL)
            reg_rdata = {{(pDATA_WIDTH-3){1'b0}}, ap_idle, ap_done, ap_start};
        else if (r_addr == ADDR_LEN)
            reg_rdata = data_length;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state    <= R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            r_addr     <= '0;
            rdata_q    <= '0;
            bram_fresh <= 1'b0;
            rd_hold    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    rd_hold <= 1'b0;
                    if (arvalid && !rd_hold) begin
                        r_state <= R_ADDR;
                        arready <= 1'b1;
                        r_addr  <= araddr;
                    end
                end
                R_ADDR: begin
                    arready <= 1'b0;
                    if (is_tap(r_addr) && ap_idle) begin
                        r_state <= R_BRAM;
                    end else begin
                        r_state <= R_DATA;
                        rvalid  <= 1'b1;
                        rdata_q <= reg_rdata;
                    end
                end
                R_BRAM: begin
                    if (!ap_idle) begin
                        r_state <= R_DATA;
                        rvalid  <= 1'b1;
                        rdata_q <= '0;
                    end else if (!wr_tap) begin
                        r_state    <= R_DATA;
                        rvalid     <= 1'b1;
                        bram_fresh <= 1'b1;
                    end
                end
                default: begin
                    if (bram_fresh) begin
                        bram_fresh <= 1'b0;
                        rdata_q    <= tap_Do;
                    end
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        rd_hold <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            ap_start_o  <= 1'b0;
            data_length <= '0;
        end else begin
            ap_start_o <= ap_start;
            if (ap_start) begin
                ap_start <= 1'b0;
                ap_idle  <= 1'b0;
                ap_done  <= 1'b0;
            end else if (w_state == W_ACK && w_addr == ADDR_CTRL && w_data[0] && ap_idle) begin
                ap_start <= 1'b1;
            end
            if (w_state == W_ACK && w_addr == ADDR_LEN && ap_idle)
                data_length <= w_data;
            if (r_state == R_DATA && rvalid && rready && r_addr == ADDR_CTRL)
                ap_done <= 1'b0;
            // done from the engine wins over a same-cycle clear-on-read
            if (eng_done_i && !ap_idle) begin
                ap_idle <= 1'b1;
                ap_done <= 1'b1;
            end
        end
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (!ap_idle) begin
            tap_EN = 1'b1;
            tap_A  = eng_tap_A;
        end else if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = w_addr - TAP_BASE;
            tap_Di = w_data;
        end else if (r_state == R_BRAM) begin
            tap_EN = 1'b1;
            tap_A  = r_addr - TAP_BASE;
        end
    end

endmodule
